// File: rtl/tog_sync_arb.sv
// Round-robin arbiter that feeds a toggle-synchronizer channel: one requester's
// word is latched and strobed per transfer, followed by a GAP-cycle hold-off.
module tog_sync_arb #(
  parameter int N    = 8,
  parameter int NREQ = 4,
  parameter int GAP  = 6
) (
  input  logic                     clkA,
  input  logic                     rst,
  input  logic                     ena,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*N-1:0]        req_data,
  output logic [NREQ-1:0]          ack,
  output logic [N-1:0]             ch_data,
  output logic                     ch_pulse,
  output logic [$clog2(NREQ)-1:0]  grant_id,
  output logic                     busy,
  output logic [15:0]              xfer_cnt
);

  localparam int IDW = $clog2(NREQ);
  localparam int CW  = (GAP < 2) ? 1 : $clog2(GAP);

  generate
    if (GAP < 2) begin : g_bad_gap
      $error("tog_sync_arb: GAP must be at least 2");
    end
    if (NREQ < 2 || NREQ > 8) begin : g_bad_nreq
      $error("tog_sync_arb: NREQ must be in 2..8");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, SEND, HOLD} state_t;

  state_t           state;
  logic [CW-1:0]    hold_cnt;
  logic [IDW-1:0]   last_grant;
  logic [IDW-1:0]   win;
  logic [IDW-1:0]   idx;
  logic             found;
  logic [N-1:0]     data_arr [NREQ];

  generate
    for (genvar i = 0; i < NREQ; i++) begin : g_unpack
      assign data_arr[i] = req_data[i*N +: N];
    end
  endgenerate

  // Search starts just after the last winner and wraps, so the first hit is the fair pick.
  always_comb begin
    win   = '0;
    idx   = '0;
    found = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = IDW'((int'(last_grant) + k) % NREQ);
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  always_ff @(posedge clkA or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      ack        <= '0;
      ch_pulse   <= 1'b0;
      ch_data    <= '0;
      grant_id   <= '0;
      busy       <= 1'b0;
      xfer_cnt   <= '0;
      hold_cnt   <= '0;
      last_grant <= IDW'(NREQ - 1);
    end else begin
      case (state)
        IDLE: begin
          if (ena && found) begin
            state      <= SEND;
            ch_data    <= data_arr[win];
            grant_id   <= win;
            last_grant <= win;
            ack        <= {{(NREQ-1){1'b0}}, 1'b1} << win;
            ch_pulse   <= 1'b1;
            busy       <= 1'b1;
          end
        end
        SEND: begin
          ack      <= '0;
          ch_pulse <= 1'b0;
          xfer_cnt <= xfer_cnt + 16'd1;
          hold_cnt <= CW'(GAP - 1);
          state    <= HOLD;
        end
        HOLD: begin
          // Counter reads GAP-1 down to 0, giving exactly GAP hold cycles.
          if (hold_cnt == '0) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            hold_cnt <= hold_cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tog_sync_arb.sv
// Bench for tog_sync_arb: table vectors, directed corner sequences and a
// randomized run, all checked against a transaction-level reference model.
module tb_tog_sync_arb;

  localparam int N    = 8;
  localparam int NREQ = 4;
  localparam int GAP  = 6;

  logic        clk = 1'b0;
  logic        rst;
  logic        ena;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  ack;
  logic [7:0]  ch_data;
  logic        ch_pulse;
  logic [1:0]  grant_id;
  logic        busy;
  logic [15:0] xfer_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  tog_sync_arb #(.N(N), .NREQ(NREQ), .GAP(GAP)) dut (
    .clkA     (clk),
    .rst      (rst),
    .ena      (ena),
    .req      (req),
    .req_data (req_data),
    .ack      (ack),
    .ch_data  (ch_data),
    .ch_pulse (ch_pulse),
    .grant_id (grant_id),
    .busy     (busy),
    .xfer_cnt (xfer_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: time of the last grant, in edges, decides everything else.
  int          edge_n = 0;
  int          g_edge;
  int          m_last;
  int          m_gid;
  logic [7:0]  m_data;
  logic [15:0] m_cnt;
  bit          m_pulse;

  task automatic model_reset();
    g_edge  = edge_n - 1000;
    m_last  = NREQ - 1;
    m_gid   = 0;
    m_data  = '0;
    m_cnt   = '0;
    m_pulse = 1'b0;
  endtask

  task automatic model_edge();
    edge_n++;
    if (rst) begin
      model_reset();
    end else begin
      m_pulse = 1'b0;
      if (edge_n == g_edge + 1) m_cnt = m_cnt + 16'd1;
      if ((edge_n - g_edge >= GAP + 2) && ena && (req != 4'b0)) begin
        for (int k = 1; k <= NREQ; k++) begin
          int c;
          c = (m_last + k) % NREQ;
          if (req[c]) begin
            m_gid   = c;
            m_last  = c;
            m_data  = req_data[c*8 +: 8];
            g_edge  = edge_n;
            m_pulse = 1'b1;
            break;
          end
        end
      end
    end
  endtask

  task automatic check_outputs();
    logic [3:0] exp_ack;
    exp_ack = m_pulse ? (4'b0001 << m_gid) : 4'b0000;
    chk("ack", ack, exp_ack);
    chk("ch_pulse", ch_pulse, m_pulse);
    chk("ch_data", ch_data, m_data);
    chk("grant_id", grant_id, m_gid);
    chk("busy", busy, (edge_n - g_edge <= GAP));
    chk("xfer_cnt", xfer_cnt, m_cnt);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_outputs();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    step();
    step();
    rst = 1'b0;
  endtask

  // Property monitor sampled on the falling edge.
  int         cyc = 0;
  int         last_pulse = -1;
  logic       pbusy = 1'b0;
  logic [7:0] pdata = '0;

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      last_pulse = -1;
      pbusy      = 1'b0;
    end else begin
      chk("onehot0_ack", $onehot0(ack), 1);
      chk("pulse_eq_ack", ch_pulse, |ack);
      if (busy && pbusy) chk("data_stable", ch_data, pdata);
      if (ch_pulse) begin
        if (last_pulse >= 0) chk("pulse_spacing_ok", (cyc - last_pulse >= GAP + 2), 1);
        last_pulse = cyc;
      end
      pbusy = busy;
      pdata = ch_data;
    end
  end

  typedef struct {
    logic       ena;
    logic [3:0] req;
    logic       exp_pulse;
    logic [1:0] exp_gid;
    logic [7:0] exp_data;
  } vec_t;

  vec_t tbl [10];

  initial begin
    int nb, np;
    int pt [8];
    int pg [8];
    logic [7:0] pd [8];
    int         fair_gid  [5];
    logic [7:0] fair_data [5];
    logic [3:0] exp_ack;

    tbl[0] = '{1'b1, 4'b0001, 1'b1, 2'd0, 8'hA5};
    tbl[1] = '{1'b1, 4'b0001, 1'b1, 2'd0, 8'hA5};
    tbl[2] = '{1'b1, 4'b0110, 1'b1, 2'd1, 8'h3C};
    tbl[3] = '{1'b1, 4'b0110, 1'b1, 2'd2, 8'h5A};
    tbl[4] = '{1'b1, 4'b0110, 1'b1, 2'd1, 8'h3C};
    tbl[5] = '{1'b1, 4'b1001, 1'b1, 2'd3, 8'hD3};
    tbl[6] = '{1'b0, 4'b1111, 1'b0, 2'd3, 8'hD3};
    tbl[7] = '{1'b1, 4'b0000, 1'b0, 2'd3, 8'hD3};
    tbl[8] = '{1'b1, 4'b1111, 1'b1, 2'd0, 8'hA5};
    tbl[9] = '{1'b1, 4'b1000, 1'b1, 2'd3, 8'hD3};
    fair_gid  = '{0, 1, 2, 3, 0};
    fair_data = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11};

    rst = 1'b1; ena = 1'b0; req = '0; req_data = '0;
    model_reset();
    #1;
    check_outputs();
    step();
    step();
    rst = 1'b0;

    // Table vectors, each applied from IDLE.
    req_data = {8'hD3, 8'h5A, 8'h3C, 8'hA5};
    for (int i = 0; i < 10; i++) begin
      ena = tbl[i].ena;
      req = tbl[i].req;
      step();
      exp_ack = tbl[i].exp_pulse ? (4'b0001 << tbl[i].exp_gid) : 4'b0000;
      chk($sformatf("tbl%0d_pulse", i), ch_pulse, tbl[i].exp_pulse);
      chk($sformatf("tbl%0d_ack", i), ack, exp_ack);
      chk($sformatf("tbl%0d_gid", i), grant_id, tbl[i].exp_gid);
      chk($sformatf("tbl%0d_data", i), ch_data, tbl[i].exp_data);
      req = '0;
      repeat (GAP + 1) step();
    end

    // Single request: pulse next cycle, busy GAP+1 cycles, one transfer counted.
    do_reset();
    ena = 1'b1; req = 4'b0001; req_data = 32'h0000_00A5;
    step();
    chk("single_pulse", ch_pulse, 1);
    chk("single_ack", ack, 4'b0001);
    chk("single_data", ch_data, 8'hA5);
    req = '0;
    nb = 1;
    repeat (12) begin
      step();
      if (busy) nb++;
    end
    chk("single_busy_len", nb, GAP + 1);
    chk("single_xfer", xfer_cnt, 1);

    // Fairness under continuous requests.
    do_reset();
    ena = 1'b1; req = 4'b1111; req_data = 32'h4433_2211;
    np = 0;
    for (int t = 0; t < 45; t++) begin
      step();
      if (ch_pulse && np < 8) begin
        pt[np] = t; pg[np] = int'(grant_id); pd[np] = ch_data; np++;
      end
    end
    req = '0;
    chk("fair_count_ge5", (np >= 5), 1);
    for (int i = 0; i < 5; i++) begin
      if (i < np) begin
        chk($sformatf("fair_gid%0d", i), pg[i], fair_gid[i]);
        chk($sformatf("fair_data%0d", i), pd[i], fair_data[i]);
        if (i > 0) chk($sformatf("fair_space%0d", i), pt[i] - pt[i-1], GAP + 2);
      end
    end
    repeat (GAP + 2) step();

    // Enable gating: nothing while low, grant right after it rises, HOLD survives a drop.
    do_reset();
    ena = 1'b0; req = 4'b0010; req_data = 32'h0000_7700;
    np = 0;
    repeat (20) begin
      step();
      if (ch_pulse) np++;
    end
    chk("ena_low_no_pulse", np, 0);
    ena = 1'b1;
    step();
    chk("ena_rise_pulse", ch_pulse, 1);
    chk("ena_rise_gid", grant_id, 1);
    chk("ena_rise_data", ch_data, 8'h77);
    nb = 1; np = 0;
    for (int k = 0; k < 12; k++) begin
      step();
      if (busy) nb++;
      if (ch_pulse) np++;
      if (k == 1) ena = 1'b0;
    end
    chk("ena_drop_hold_len", nb, GAP + 1);
    chk("ena_drop_no_pulse", np, 0);
    ena = 1'b1;
    step();
    chk("held_req_served", ch_pulse, 1);
    req = '0;
    repeat (GAP + 1) step();

    // Asynchronous reset in the third HOLD cycle.
    do_reset();
    ena = 1'b1; req = 4'b0001; req_data = 32'h00AA_BBCC;
    step();
    req = '0;
    repeat (3) step();
    chk("pre_rst_busy", busy, 1);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    chk("arst_ack", ack, 0);
    chk("arst_pulse", ch_pulse, 0);
    chk("arst_data", ch_data, 0);
    chk("arst_gid", grant_id, 0);
    chk("arst_busy", busy, 0);
    chk("arst_xfer", xfer_cnt, 0);
    step();
    step();
    rst = 1'b0;
    req = 4'b0100;
    step();
    chk("post_rst_pulse", ch_pulse, 1);
    chk("post_rst_gid", grant_id, 2);
    chk("post_rst_data", ch_data, 8'hAA);
    req = '0;
    repeat (GAP + 1) step();
    chk("post_rst_xfer", xfer_cnt, 1);

    // Transfer counter wrap from a preloaded 0xFFFF.
    do_reset();
    req = '0;
    force dut.xfer_cnt = 16'hFFFF;
    m_cnt = 16'hFFFF;
    step();
    release dut.xfer_cnt;
    step();
    chk("wrap_preload", xfer_cnt, 16'hFFFF);
    req = 4'b0001;
    step();
    req = '0;
    step();
    chk("wrap_zero", xfer_cnt, 16'h0000);
    repeat (GAP + 1) step();

    // Randomized traffic against the model.
    do_reset();
    for (int t = 0; t < 3000; t++) begin
      ena = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 3) == 0) req = 4'($urandom);
      if ($urandom_range(0, 2) == 0) req_data = $urandom;
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
